// File: rtl/univ_shift_reg_pkg.sv
// Shared mode codes and drain-tracker state encoding for univ_shift_reg.
// Pure definitions: no latency, no backpressure.
`timescale 1ns/1ps
package univ_shift_reg_pkg;

  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOADED  = 2'd1,
    ST_DRAINED = 2'd2
  } state_t;

  function automatic logic is_shift_mode(input logic [1:0] mode);
    return (mode == MODE_SHR) || (mode == MODE_SHL);
  endfunction

endpackage

// File: rtl/univ_shift_reg_sat_counter.sv
// Up-counter with synchronous clear that sticks at MAX; 1-cycle latency.
// No backpressure: iInc at MAX is simply absorbed.
`timescale 1ns/1ps
module sat_counter #(
  parameter int MAX = 8,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic         iclk,
  input  logic         irst,
  input  logic         iClr,
  input  logic         iInc,
  output logic [W-1:0] oCnt,
  output logic         oMax
);

  localparam logic [W-1:0] MAX_V = W'(MAX);

  assign oMax = (oCnt == MAX_V);

  always_ff @(posedge iclk) begin
    if (irst) begin
      oCnt <= '0;
    end else if (iClr) begin
      oCnt <= '0;
    end else if (iInc && !oMax) begin
      oCnt <= oCnt + 1'b1;
    end
  end

endmodule

// File: rtl/univ_shift_reg.sv
// WIDTH-bit hold/shift/rotate/load register with a drain tracker; all outputs 1-cycle, oQN combinational.
// No backpressure: iEn=0 freezes data, count and state; oDone is a single-cycle pulse.
`timescale 1ns/1ps
module univ_shift_reg
  import univ_shift_reg_pkg::*;
#(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               ROTATE    = 1'b0,
  localparam int              CW        = $clog2(WIDTH + 1)
) (
  input  logic             iclk,
  input  logic             irst,
  input  logic             iEn,
  input  logic [1:0]       iMode,
  input  logic             iSR,
  input  logic             iSL,
  input  logic [WIDTH-1:0] iD,
  output logic [WIDTH-1:0] oQ,
  output logic [WIDTH-1:0] oQN,
  output logic             oSO,
  output logic [CW-1:0]    oCnt,
  output logic             oBusy,
  output logic             oDone
);

  localparam logic [CW-1:0] LAST_SHIFT = CW'(WIDTH - 1);

  state_t state;
  logic   do_shr, do_shl, do_load, do_shift;
  logic   fill_r, fill_l;
  logic   cnt_max;

  assign do_load  = iEn && (iMode == MODE_LOAD);
  assign do_shr   = iEn && (iMode == MODE_SHR);
  assign do_shl   = iEn && (iMode == MODE_SHL);
  assign do_shift = iEn && is_shift_mode(iMode);

  assign fill_r = ROTATE ? oQ[0]       : iSR;
  assign fill_l = ROTATE ? oQ[WIDTH-1] : iSL;

  assign oQN = ~oQ;

  always_ff @(posedge iclk) begin
    if (irst) begin
      oQ  <= RESET_VAL;
      oSO <= 1'b0;
    end else if (do_load) begin
      oQ  <= iD;
    end else if (do_shr) begin
      oQ  <= {fill_r, oQ[WIDTH-1:1]};
      oSO <= oQ[0];
    end else if (do_shl) begin
      oQ  <= {oQ[WIDTH-2:0], fill_l};
      oSO <= oQ[WIDTH-1];
    end
  end

  // Only shifts of a freshly loaded word are counted; the count then parks at WIDTH.
  sat_counter #(.MAX(WIDTH), .W(CW)) u_cnt (
    .iclk (iclk),
    .irst (irst),
    .iClr (do_load),
    .iInc (do_shift && (state == ST_LOADED) && !cnt_max),
    .oCnt (oCnt),
    .oMax (cnt_max)
  );

  always_ff @(posedge iclk) begin
    if (irst) begin
      state <= ST_IDLE;
      oBusy <= 1'b0;
      oDone <= 1'b0;
    end else begin
      oDone <= 1'b0;
      case (state)
        ST_IDLE, ST_DRAINED: begin
          if (do_load) begin
            state <= ST_LOADED;
            oBusy <= 1'b1;
          end
        end
        ST_LOADED: begin
          if (!do_load && do_shift && (oCnt == LAST_SHIFT)) begin
            state <= ST_DRAINED;
            oBusy <= 1'b0;
            oDone <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
          oBusy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Scoreboard bench for univ_shift_reg: one shifting and one rotating instance share stimulus.
`timescale 1ns/1ps
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, en, sr, sl;
  logic [1:0] mode;
  logic [7:0] d;

  logic [7:0] q_n, qn_n, q_r, qn_r;
  logic       so_n, so_r, busy_n, busy_r, done_n, done_r;
  logic [3:0] cnt_n, cnt_r;

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5), .ROTATE(1'b0)) dut_n (
    .iclk(clk), .irst(rst), .iEn(en), .iMode(mode), .iSR(sr), .iSL(sl), .iD(d),
    .oQ(q_n), .oQN(qn_n), .oSO(so_n), .oCnt(cnt_n), .oBusy(busy_n), .oDone(done_n)
  );

  univ_shift_reg #(.WIDTH(8), .RESET_VAL(8'hA5), .ROTATE(1'b1)) dut_r (
    .iclk(clk), .irst(rst), .iEn(en), .iMode(mode), .iSR(sr), .iSL(sl), .iD(d),
    .oQ(q_r), .oQN(qn_r), .oSO(so_r), .oCnt(cnt_r), .oBusy(busy_r), .oDone(done_r)
  );

  localparam bit [4:0] M_Q = 5'd1, M_SO = 5'd2, M_CNT = 5'd4, M_BUSY = 5'd8, M_DONE = 5'd16;
  localparam bit [4:0] M_ALL = 5'd31;

  // Hand-computed tables.
  localparam logic [7:0] SHR_Q  [8] = '{8'h4B, 8'h25, 8'h12, 8'h09, 8'h04, 8'h02, 8'h01, 8'h00};
  localparam logic       SHR_SO [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
  localparam logic [7:0] ROT_Q  [8] = '{8'h06, 8'h0C, 8'h18, 8'h30, 8'h60, 8'hC0, 8'h81, 8'h03};
  localparam logic       ROT_SO [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
  localparam bit         EN5    [11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
  localparam logic [7:0] T5_Q   [9] = '{8'h3C, 8'h78, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h00, 8'h00};
  localparam logic       T5_SO  [9] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam logic [7:0] T6_Q   [3] = '{8'h52, 8'h29, 8'h14};
  localparam logic       T6_SO  [3] = '{1'b1, 1'b0, 1'b1};

  typedef struct {
    string      nm;
    bit         rot;
    bit [4:0]   m;
    logic [7:0] q;
    logic       so;
    logic [3:0] cnt;
    logic       busy;
    logic       done;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   k5;

  task automatic cmp(input string nm, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Monitor: every expectation queued in the previous half-cycle is checked here.
  always @(negedge clk) begin
    while (sb.size() > 0) begin
      mon_e = sb.pop_front();
      if (mon_e.m[0]) begin
        cmp({mon_e.nm, ".q"},  mon_e.rot ? q_r  : q_n,  mon_e.q);
        cmp({mon_e.nm, ".qn"}, mon_e.rot ? qn_r : qn_n, ~mon_e.q);
      end
      if (mon_e.m[1]) cmp({mon_e.nm, ".so"},   {7'd0, mon_e.rot ? so_r   : so_n},   {7'd0, mon_e.so});
      if (mon_e.m[2]) cmp({mon_e.nm, ".cnt"},  {4'd0, mon_e.rot ? cnt_r  : cnt_n},  {4'd0, mon_e.cnt});
      if (mon_e.m[3]) cmp({mon_e.nm, ".busy"}, {7'd0, mon_e.rot ? busy_r : busy_n}, {7'd0, mon_e.busy});
      if (mon_e.m[4]) cmp({mon_e.nm, ".done"}, {7'd0, mon_e.rot ? done_r : done_n}, {7'd0, mon_e.done});
    end
  end

  task automatic push(input string nm, input bit rot, input bit [4:0] m, input logic [7:0] q,
                      input logic so, input logic [3:0] cnt, input logic busy, input logic done);
    exp_t e;
    e.nm = nm; e.rot = rot; e.m = m; e.q = q; e.so = so; e.cnt = cnt; e.busy = busy; e.done = done;
    sb.push_back(e);
  endtask

  task automatic cyc(input logic e, input logic [1:0] md, input logic s_r, input logic [7:0] dd);
    en = e; mode = md; sr = s_r; d = dd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst = 1'b0; en = 1'b0; mode = 2'b00; sr = 1'b0; sl = 1'b0; d = 8'h00;
    @(posedge clk);
    #1;

    // Reset overrides a concurrent load.
    rst = 1'b1;
    cyc(1'b1, 2'b11, 1'b0, 8'hFF);
    rst = 1'b0;
    push("reset_n", 1'b0, M_ALL, 8'hA5, 1'b0, 4'd0, 1'b0, 1'b0);
    push("reset_r", 1'b1, M_ALL, 8'hA5, 1'b0, 4'd0, 1'b0, 1'b0);

    // Load 1001_0110 and drain it right with zero fill.
    cyc(1'b1, 2'b11, 1'b0, 8'h96);
    push("load96", 1'b0, M_Q | M_CNT | M_BUSY | M_DONE, 8'h96, 1'b0, 4'd0, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b1, 2'b01, 1'b0, 8'h00);
      push($sformatf("shr%0d", k), 1'b0, M_ALL, SHR_Q[k-1], SHR_SO[k-1], 4'(k), (k < 8), (k == 8));
    end
    cyc(1'b1, 2'b01, 1'b1, 8'h00);
    push("drained_shr", 1'b0, M_ALL, 8'h80, 1'b0, 4'd8, 1'b0, 1'b0);
    cyc(1'b1, 2'b00, 1'b0, 8'h55);
    push("hold", 1'b0, M_ALL, 8'h80, 1'b0, 4'd8, 1'b0, 1'b0);

    // Rotate-left instance: serial input driven high must be ignored.
    cyc(1'b1, 2'b11, 1'b0, 8'h81);
    push("rot_load", 1'b1, M_Q | M_CNT | M_BUSY | M_DONE, 8'h81, 1'b0, 4'd0, 1'b1, 1'b0);
    sl = 1'b1;
    cyc(1'b1, 2'b10, 1'b0, 8'h00);
    push("rot_shl1", 1'b1, M_ALL, 8'h03, 1'b1, 4'd1, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++) begin
      cyc(1'b1, 2'b10, 1'b0, 8'h00);
      push($sformatf("rot_shl%0d", k + 2), 1'b1, M_ALL, ROT_Q[k], ROT_SO[k],
           (k < 7) ? 4'(k + 2) : 4'd8, (k < 6), (k == 6));
    end
    sl = 1'b0;

    // Reload mid-drain restarts the count.
    cyc(1'b1, 2'b11, 1'b0, 8'hFF);
    for (int k = 0; k < 4; k++) cyc(1'b1, 2'b01, 1'b0, 8'h00);
    push("pre_reload", 1'b0, M_Q | M_CNT | M_BUSY, 8'h0F, 1'b0, 4'd4, 1'b1, 1'b0);
    cyc(1'b1, 2'b11, 1'b0, 8'h0F);
    push("reload", 1'b0, M_Q | M_CNT | M_BUSY | M_DONE, 8'h0F, 1'b0, 4'd0, 1'b1, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      cyc(1'b1, 2'b01, 1'b0, 8'h00);
      push($sformatf("reload_shr%0d", k), 1'b0, M_CNT | M_BUSY | M_DONE, 8'h00, 1'b0,
           4'(k), (k < 8), (k == 8));
    end
    push("reload_final", 1'b0, M_Q, 8'h00, 1'b0, 4'd0, 1'b0, 1'b0);

    // Enable gaps among eight left shifts; one gap carries a load code.
    cyc(1'b1, 2'b11, 1'b0, 8'h3C);
    push("en_load", 1'b0, M_Q | M_CNT | M_BUSY | M_DONE, 8'h3C, 1'b0, 4'd0, 1'b1, 1'b0);
    k5 = 0;
    for (int i = 0; i < 11; i++) begin
      if (EN5[i]) begin
        cyc(1'b1, 2'b10, 1'b0, 8'h00);
        k5++;
      end else begin
        cyc(1'b0, (i == 5) ? 2'b11 : 2'b10, 1'b0, 8'hFF);
      end
      push($sformatf("en_step%0d", i), 1'b0, (k5 > 0) ? M_ALL : (M_ALL & ~M_SO),
           T5_Q[k5], T5_SO[k5], 4'(k5), (k5 < 8), (EN5[i] && k5 == 8));
    end

    // Reset mid-drain aborts; later shifts in IDLE are not counted.
    cyc(1'b1, 2'b11, 1'b0, 8'h55);
    for (int k = 0; k < 5; k++) cyc(1'b1, 2'b01, 1'b0, 8'h00);
    push("pre_abort", 1'b0, M_Q | M_CNT | M_BUSY, 8'h02, 1'b0, 4'd5, 1'b1, 1'b0);
    rst = 1'b1;
    cyc(1'b1, 2'b01, 1'b0, 8'h00);
    rst = 1'b0;
    push("abort", 1'b0, M_ALL, 8'hA5, 1'b0, 4'd0, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      cyc(1'b1, 2'b01, 1'b0, 8'h00);
      push($sformatf("idle_shr%0d", k + 1), 1'b0, M_ALL, T6_Q[k], T6_SO[k], 4'd0, 1'b0, 1'b0);
    end

    cyc(1'b0, 2'b00, 1'b0, 8'h00);
    cyc(1'b0, 2'b00, 1'b0, 8'h00);
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
